dead_time_nch: RTL and testbench
================================

DEAD_TIME_NCH -- requirements
Module: dead_time_nch

Interface
REQ-001 Parameter N_CH, default 4: number of independent complementary PWM legs.
REQ-002 Parameter DT_W, default 10: dead-time count width in clock cycles.
REQ-003 The module SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-004 clk  in  1  system clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 pwm  in  N_CH  raw modulator output per channel; bit i drives leg i.
REQ-007 dt_a_in  in  N_CH*DT_W  requested A-side dead time per channel; channel i occupies bits [i*DT_W +: DT_W].
REQ-008 dt_b_in  in  N_CH*DT_W  requested B-side dead time per channel; same packing as dt_a_in.
REQ-009 dt_load  in  1  single-cycle strobe; copies dt_a_in and dt_b_in into the active registers.
REQ-010 pol_a, pol_b  in  N_CH each  output polarity per leg; 1 = active-high, 0 = active-low.
REQ-011 pwm_en  in  1  global output enable.
REQ-012 dt_en  in  1  dead-time insertion enable.
REQ-013 fault  in  1  external trip input, synchronous to clk.
REQ-014 fault_clr  in  1  trip clear request.
REQ-015 pwmout_a, pwmout_b  out  N_CH each  gated, polarity-adjusted gate drives.
REQ-016 fault_latched  out  1  trip status.

Function
REQ-017 Per channel, the block SHALL hold registered legs aux_a and aux_b, DT_W-bit counters cnt_a and cnt_b, and active registers dta and dtb.
REQ-018 With dt_en=1 and pwm[i]=1: aux_b SHALL be driven to 0 on the next edge and cnt_b cleared.
REQ-019 With dt_en=1 and pwm[i]=1, once aux_a=0:
  - if cnt_a<dta, cnt_a SHALL increment;
  - otherwise aux_a SHALL be set to 1 and cnt_a cleared;
  - while aux_a=1 it SHALL hold.
REQ-020 pwm[i]=0 SHALL behave symmetrically: aux_a is cleared, and aux_b is counted up against dtb.
REQ-021 For a pwm edge first sampled at edge E0, the incoming leg SHALL assert after edge E0+dt. The outgoing leg SHALL deassert after E0. Both legs are therefore low for exactly dt cycles; dt=0 gives zero gap and one-cycle latency.
REQ-022 If pwm toggles back before the count completes, the pending leg SHALL never assert (minimum-pulse suppression) and its counter SHALL clear.
REQ-023 aux_a and aux_b SHALL never both be 1 in any cycle, for any input sequence.
REQ-024 With dt_en=0:
  - aux_a SHALL equal pwm registered and aux_b SHALL equal ~pwm registered, one-cycle latency;
  - counters SHALL be held at 0.
REQ-025 On dt_load=1, dta and dtb for all channels SHALL update at that edge. A count already in progress SHALL compare against the new value from the next edge.
REQ-026 The counters SHALL never exceed the active dead time, so no wrap-around occurs. A new value below the current count SHALL cause immediate assertion on the next edge.
REQ-027 fault=1 SHALL set fault_latched on that edge.
REQ-028 fault_latched SHALL clear only on an edge with fault_clr=1 and fault=0. When fault and fault_clr are both 1, fault SHALL win.
REQ-029 While fault_latched=1, all aux legs and counters SHALL be held at 0. After clear, legs SHALL restart with full dead-time insertion.
REQ-030 The outputs SHALL be combinational from registered state:
  - pwmout_a[i] = (aux_a XNOR pol_a[i]) AND pwm_en AND NOT fault_latched, and likewise pwmout_b[i] with aux_b and pol_b[i];
  - when gated off, an output SHALL be 0 regardless of polarity.
REQ-031 Channels SHALL be fully independent except for the shared dt_load, pwm_en, dt_en and fault.

Reset
REQ-032 While reset=1, all aux legs, counters and fault_latched SHALL be 0. Hence pwmout_a and pwmout_b SHALL be 0.
REQ-033 Reset SHALL load dta and dtb with 0.
REQ-034 Reset asserted mid-count SHALL abort all counts immediately. After release, the first pwm level SHALL incur the full dead time.

Verification (N_CH=4, DT_W=10, pols=1, pwm_en=1, dt_en=1)
REQ-035 Load dta=dtb=5, then toggle pwm[0] 0->1 at E0 -> pwmout_b[0] falls after E0, pwmout_a[0] rises after E5, and both are low for exactly 5 cycles.
REQ-036 dta=8, with a 3-cycle high pulse on pwm[1] -> pwmout_a[1] stays 0 throughout, and pwmout_b[1] drops for 3 cycles and then re-asserts after 8 more cycles.
REQ-037 dt_en=0 with pwm[2] toggling every cycle -> pwmout_a[2]=pwm delayed by 1 cycle and pwmout_b[2]=its complement; counters stay 0.
REQ-038 Assert fault mid-count, then apply fault_clr together with fault=1 -> outputs are 0 and fault_latched stays 1. Then fault_clr with fault=0 -> latch clears and the legs resume with full dead time.
REQ-039 pol_a[3]=0, pwm_en=0 -> pwmout_a[3]=0. pwm_en=1 with aux_a=0 -> pwmout_a[3]=1.
REQ-040 Random pwm, dt_load and fault stimulus across all channels -> the assertion aux_a AND aux_b = 0 never fails, and no counter exceeds its active dead time.

Source files
------------

// File: rtl/dead_time_nch.sv
`default_nettype none
// ============================================================================
// Module      : dead_time_nch
// Description : N-channel complementary PWM dead-time generator with
//               per-channel A/B delays, polarity, global enable and fault trip.
// Revision    : 1.0 - initial release
// ============================================================================
module dead_time_nch #(
    parameter int N_CH = 4,
    parameter int DT_W = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_CH-1:0]        pwm,
    input  logic [N_CH*DT_W-1:0]   dt_a_in,
    input  logic [N_CH*DT_W-1:0]   dt_b_in,
    input  logic                   dt_load,
    input  logic [N_CH-1:0]        pol_a,
    input  logic [N_CH-1:0]        pol_b,
    input  logic                   pwm_en,
    input  logic                   dt_en,
    input  logic                   fault,
    input  logic                   fault_clr,
    output logic [N_CH-1:0]        pwmout_a,
    output logic [N_CH-1:0]        pwmout_b,
    output logic                   fault_latched
);

    localparam logic [DT_W-1:0] c_CNT_ONE = {{(DT_W-1){1'b0}}, 1'b1};

    logic r_fault_latched;

    // A new trip always beats a simultaneous clear request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fault_latched <= 1'b0;
        end else if (fault) begin
            r_fault_latched <= 1'b1;
        end else if (fault_clr) begin
            r_fault_latched <= 1'b0;
        end
    end

    assign fault_latched = r_fault_latched;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic            r_aux_a;
        logic            r_aux_b;
        logic [DT_W-1:0] r_cnt_a;
        logic [DT_W-1:0] r_cnt_b;
        logic [DT_W-1:0] r_dta;
        logic [DT_W-1:0] r_dtb;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_aux_a <= 1'b0;
                r_aux_b <= 1'b0;
                r_cnt_a <= '0;
                r_cnt_b <= '0;
                r_dta   <= '0;
                r_dtb   <= '0;
            end else begin
                if (dt_load) begin
                    r_dta <= dt_a_in[gi*DT_W +: DT_W];
                    r_dtb <= dt_b_in[gi*DT_W +: DT_W];
                end

                if (r_fault_latched) begin
                    r_aux_a <= 1'b0;
                    r_aux_b <= 1'b0;
                    r_cnt_a <= '0;
                    r_cnt_b <= '0;
                end else if (!dt_en) begin
                    r_aux_a <= pwm[gi];
                    r_aux_b <= ~pwm[gi];
                    r_cnt_a <= '0;
                    r_cnt_b <= '0;
                end else if (pwm[gi]) begin
                    // Outgoing leg drops at once; incoming leg waits out dta.
                    r_aux_b <= 1'b0;
                    r_cnt_b <= '0;
                    if (!r_aux_a) begin
                        if (r_cnt_a < r_dta) begin
                            r_cnt_a <= r_cnt_a + c_CNT_ONE;
                        end else begin
                            r_aux_a <= 1'b1;
                            r_cnt_a <= '0;
                        end
                    end
                end else begin
                    r_aux_a <= 1'b0;
                    r_cnt_a <= '0;
                    if (!r_aux_b) begin
                        if (r_cnt_b < r_dtb) begin
                            r_cnt_b <= r_cnt_b + c_CNT_ONE;
                        end else begin
                            r_aux_b <= 1'b1;
                            r_cnt_b <= '0;
                        end
                    end
                end
            end
        end

        // Gate with reset too, so active-low legs stay off while in reset.
        assign pwmout_a[gi] = ~(r_aux_a ^ pol_a[gi]) & pwm_en & ~r_fault_latched & ~reset;
        assign pwmout_b[gi] = ~(r_aux_b ^ pol_b[gi]) & pwm_en & ~r_fault_latched & ~reset;
    end

endmodule
`default_nettype wire

// File: tb/tb_dead_time_nch.sv
`default_nettype none
// ============================================================================
// Module      : tb_dead_time_nch
// Description : Self-checking bench for dead_time_nch against an elapsed-time
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dead_time_nch;

    localparam int N_CH = 4;
    localparam int DT_W = 10;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N_CH-1:0]      pwm;
    logic [N_CH*DT_W-1:0] dt_a_in;
    logic [N_CH*DT_W-1:0] dt_b_in;
    logic                 dt_load;
    logic [N_CH-1:0]      pol_a;
    logic [N_CH-1:0]      pol_b;
    logic                 pwm_en;
    logic                 dt_en;
    logic                 fault;
    logic                 fault_clr;
    logic [N_CH-1:0]      pwmout_a;
    logic [N_CH-1:0]      pwmout_b;
    logic                 fault_latched;

    dead_time_nch #(.N_CH(N_CH), .DT_W(DT_W)) u_dut (
        .clk           (clk),
        .reset         (reset),
        .pwm           (pwm),
        .dt_a_in       (dt_a_in),
        .dt_b_in       (dt_b_in),
        .dt_load       (dt_load),
        .pol_a         (pol_a),
        .pol_b         (pol_b),
        .pwm_en        (pwm_en),
        .dt_en         (dt_en),
        .fault         (fault),
        .fault_clr     (fault_clr),
        .pwmout_a      (pwmout_a),
        .pwmout_b      (pwmout_b),
        .fault_latched (fault_latched)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: a leg turns on at the first edge where the number of edges
    // already spent waiting at the current pwm level reaches its dead time.
    bit m_a[N_CH];
    bit m_b[N_CH];
    bit m_wait_lvl[N_CH];
    int m_waited[N_CH];
    int m_dta[N_CH];
    int m_dtb[N_CH];
    bit m_fl;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_a[i] = 1'b0;  m_b[i] = 1'b0;
            m_waited[i] = 0; m_wait_lvl[i] = 1'b0;
            m_dta[i] = 0;   m_dtb[i] = 0;
        end
        m_fl = 1'b0;
    endtask

    task automatic model_edge();
        bit p;
        int k;
        int dt;
        if (reset) begin
            model_reset();
            return;
        end
        for (int i = 0; i < N_CH; i++) begin
            p = pwm[i];
            if (m_fl) begin
                m_a[i] = 1'b0; m_b[i] = 1'b0; m_waited[i] = 0;
            end else if (!dt_en) begin
                m_a[i] = p; m_b[i] = !p; m_waited[i] = 0;
            end else begin
                if (p) m_b[i] = 1'b0; else m_a[i] = 1'b0;
                if ((p && m_a[i]) || (!p && m_b[i])) begin
                    m_waited[i] = 0;
                end else begin
                    k  = (m_wait_lvl[i] == p) ? m_waited[i] : 0;
                    dt = p ? m_dta[i] : m_dtb[i];
                    if (k >= dt) begin
                        if (p) m_a[i] = 1'b1; else m_b[i] = 1'b1;
                        m_waited[i] = 0;
                    end else begin
                        m_waited[i] = k + 1;
                        m_wait_lvl[i] = p;
                    end
                end
            end
            if (dt_load) begin
                m_dta[i] = int'(dt_a_in[i*DT_W +: DT_W]);
                m_dtb[i] = int'(dt_b_in[i*DT_W +: DT_W]);
            end
        end
        if (fault) m_fl = 1'b1;
        else if (fault_clr) m_fl = 1'b0;
    endtask

    task automatic compare_all();
        logic [N_CH-1:0] ea, eb, ra, rb;
        for (int i = 0; i < N_CH; i++) begin
            ea[i] = ~(m_a[i] ^ pol_a[i]) & pwm_en & ~m_fl & ~reset;
            eb[i] = ~(m_b[i] ^ pol_b[i]) & pwm_en & ~m_fl & ~reset;
        end
        check("pwmout_a", 32'(pwmout_a), 32'(ea));
        check("pwmout_b", 32'(pwmout_b), 32'(eb));
        check("fault_latched", 32'(fault_latched), 32'(m_fl));
        if (pwm_en && !m_fl && !reset) begin
            ra = ~(pwmout_a ^ pol_a);
            rb = ~(pwmout_b ^ pol_b);
            check("legs_exclusive", 32'(ra & rb), 32'd0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic set_dt(input int a, input int b);
        for (int i = 0; i < N_CH; i++) begin
            dt_a_in[i*DT_W +: DT_W] = DT_W'(a);
            dt_b_in[i*DT_W +: DT_W] = DT_W'(b);
        end
    endtask

    task automatic load_dt(input int a, input int b);
        set_dt(a, b);
        dt_load = 1'b1;
        step();
        dt_load = 1'b0;
    endtask

    initial begin
        bit s;
        reset = 1'b1; pwm = '0; dt_a_in = '0; dt_b_in = '0; dt_load = 1'b0;
        pol_a = '1; pol_b = '1; pwm_en = 1'b1; dt_en = 1'b1;
        fault = 1'b0; fault_clr = 1'b0;
        model_reset();
        step();
        step();
        check("reset_outputs", 32'({pwmout_a, pwmout_b}), 32'd0);
        reset = 1'b0;

        // 5-cycle gap on a rising edge of channel 0
        load_dt(5, 5);
        repeat (3) step();
        check("idle_b0_on", 32'(pwmout_b[0]), 32'd1);
        pwm[0] = 1'b1;
        step();
        check("e0_b0_off", 32'(pwmout_b[0]), 32'd0);
        check("e0_a0_off", 32'(pwmout_a[0]), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            step();
            check("dt5_a0", 32'(pwmout_a[0]), 32'(k == 5));
        end

        // 3-cycle pulse shorter than an 8-cycle dead time is suppressed
        load_dt(8, 8);
        pwm[1] = 1'b1;
        repeat (3) begin
            step();
            check("short_a1", 32'(pwmout_a[1]), 32'd0);
            check("short_b1", 32'(pwmout_b[1]), 32'd0);
        end
        pwm[1] = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            step();
            check("short_a1_after", 32'(pwmout_a[1]), 32'd0);
            check("reassert_b1", 32'(pwmout_b[1]), 32'(k == 8));
        end

        // Bypass: outputs follow pwm with one cycle of latency
        dt_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            pwm[2] = ~pwm[2];
            s = pwm[2];
            step();
            check("bypass_a2", 32'(pwmout_a[2]), 32'(s));
            check("bypass_b2", 32'(pwmout_b[2]), 32'(!s));
        end
        dt_en = 1'b1;

        // Trip mid-count; clear is refused while fault is still high
        load_dt(5, 5);
        pwm[3] = 1'b1;
        step();
        step();
        fault = 1'b1;
        step();
        check("trip_latched", 32'(fault_latched), 32'd1);
        fault_clr = 1'b1;
        step();
        check("clr_refused", 32'(fault_latched), 32'd1);
        check("trip_out_zero", 32'({pwmout_a, pwmout_b}), 32'd0);
        fault = 1'b0;
        step();
        check("clr_accepted", 32'(fault_latched), 32'd0);
        fault_clr = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            step();
            check("restart_a3", 32'(pwmout_a[3]), 32'(k == 5));
        end

        // Active-low A leg with global enable
        pwm[3] = 1'b0;
        step();
        pol_a[3] = 1'b0;
        pwm_en = 1'b0;
        #1;
        check("pol_en_off", 32'(pwmout_a[3]), 32'd0);
        pwm_en = 1'b1;
        #1;
        check("pol_en_on", 32'(pwmout_a[3]), 32'd1);
        pol_a = '1;

        // Randomized traffic with one asynchronous reset mid-stream
        for (int it = 0; it < 800; it++) begin
            for (int i = 0; i < N_CH; i++)
                if ($urandom_range(7) == 0) pwm[i] = ~pwm[i];
            dt_load = ($urandom_range(19) == 0);
            if (dt_load)
                for (int i = 0; i < N_CH; i++) begin
                    dt_a_in[i*DT_W +: DT_W] = DT_W'($urandom_range(7));
                    dt_b_in[i*DT_W +: DT_W] = DT_W'($urandom_range(7));
                end
            fault     = ($urandom_range(59) == 0);
            fault_clr = ($urandom_range(7) == 0);
            if ($urandom_range(39) == 0) dt_en = ~dt_en;
            if ($urandom_range(49) == 0) begin
                pol_a = N_CH'($urandom);
                pol_b = N_CH'($urandom);
            end
            if (it == 400) begin
                reset = 1'b1;
                model_reset();
                #1;
                compare_all();
                step();
                reset = 1'b0;
            end else begin
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
